mdu_ctrl: RTL and testbench

//  Multiply/divide unit with its sequencing controller. Sits in the E stage beside the ALU.

---
 rtl/mdu_ctrl_pkg.sv | 32 +++
 rtl/mdu_ctrl_arith.sv | 71 +++++++
 rtl/mdu_ctrl.sv | 118 +++++++++++
 tb/tb_mdu_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg
//   Shared constants for the multiply/divide unit: operation codes driven on
//   MDUcal, write codes driven on MDUwrite, the controller state type and a
//   few small opcode-classification helpers.
package mdu_ctrl_pkg;

  // MDUcal operation codes (5..15 are undefined and behave as none)
  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] SIGN_MULT = 4'd1;
  localparam logic [3:0] ZERO_MULT = 4'd2;
  localparam logic [3:0] SIGN_DIV  = 4'd3;
  localparam logic [3:0] ZERO_DIV  = 4'd4;

  // MDUwrite codes (mthi / mtlo)
  localparam logic [3:0] WR_NONE = 4'd0;
  localparam logic [3:0] WHI     = 4'd1;
  localparam logic [3:0] WLO     = 4'd2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  function automatic logic is_div(input logic [3:0] op);
    return (op == SIGN_DIV) || (op == ZERO_DIV);
  endfunction

  function automatic logic is_valid_op(input logic [3:0] op);
    return (op >= SIGN_MULT) && (op <= ZERO_DIV);
  endfunction

endpackage

// File: rtl/mdu_ctrl_arith.sv
// mdu_arith
//   Combinational datapath for the MDU. Produces the HI/LO pair that the
//   selected operation would write, plus a divide-by-zero flag.
// Ports
//   i_op    in   4      MDUcal operation code
//   i_a     in   WIDTH  rs operand (multiplicand / dividend)
//   i_b     in   WIDTH  rt operand (multiplier / divisor)
//   o_hi    out  WIDTH  product high half, or remainder
//   o_lo    out  WIDTH  product low half, or quotient
//   o_div0  out  1      divide op with zero divisor (result must be discarded)
module mdu_arith
  import mdu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_div0
);

  logic [2*WIDTH-1:0]        w_smul;
  logic [2*WIDTH-1:0]        w_umul;
  logic [WIDTH-1:0]          w_b_safe;
  logic signed [WIDTH-1:0]   w_sa;
  logic signed [WIDTH-1:0]   w_sb;
  logic signed [WIDTH-1:0]   w_sq;
  logic signed [WIDTH-1:0]   w_sr;
  logic [WIDTH-1:0]          w_uq;
  logic [WIDTH-1:0]          w_ur;

  // Full-width products: extend both operands to 2*WIDTH so the low 2*WIDTH
  // bits of the product are exact for both signed and unsigned forms.
  assign w_smul = {{WIDTH{i_a[WIDTH-1]}}, i_a} * {{WIDTH{i_b[WIDTH-1]}}, i_b};
  assign w_umul = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

  assign o_div0 = is_div(i_op) && (i_b == '0);

  // Substitute a divisor of 1 on zero so the divider never sees x/0; the
  // result is thrown away by the controller anyway.
  assign w_b_safe = (i_b == '0) ? WIDTH'(1) : i_b;
  assign w_sa     = $signed(i_a);
  assign w_sb     = $signed(w_b_safe);

  // Signed '/' and '%' truncate toward zero; remainder takes dividend's sign.
  assign w_sq = w_sa / w_sb;
  assign w_sr = w_sa % w_sb;
  assign w_uq = i_a / w_b_safe;
  assign w_ur = i_a % w_b_safe;

  always_comb begin
    o_hi = '0;
    o_lo = '0;
    case (i_op)
      SIGN_MULT: {o_hi, o_lo} = w_smul;
      ZERO_MULT: {o_hi, o_lo} = w_umul;
      SIGN_DIV: begin
        o_hi = w_sr;
        o_lo = w_sq;
      end
      ZERO_DIV: begin
        o_hi = w_ur;
        o_lo = w_uq;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl
//   E-stage multiply/divide unit and sequencer. Starts a mult/div when the
//   E-stage instruction asks for it, holds busy for the op latency, then
//   commits the result to the architectural HI/LO registers. Also handles
//   mthi/mtlo and generates the D-stage stall for md-class instructions.
// Ports
//   clk       in   1      clock
//   reset     in   1      asynchronous active-high reset
//   start     in   1      E-stage instr is mult/multu/div/divu
//   MDUcal    in   4      operation code
//   MDUwrite  in   4      mthi/mtlo write code
//   flush     in   1      E-stage instr cancelled; blocks start and write
//   A, B      in   WIDTH  forwarded rs / rt values
//   md_D      in   1      D-stage instr is md-class
//   busy      out  1      op in progress
//   stall     out  1      freeze F/D, bubble into E
//   HI, LO    out  WIDTH  architectural HI / LO
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       MDUcal,
  input  logic [3:0]       MDUwrite,
  input  logic             flush,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             md_D,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  mdu_state_e       r_state;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_hi_n;
  logic [WIDTH-1:0] r_lo_n;
  logic             r_upd;   // clear when the pending result is a div-by-zero
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic             w_div0;
  logic             w_go;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .i_op   (MDUcal),
    .i_a    (A),
    .i_b    (B),
    .o_hi   (w_hi),
    .o_lo   (w_lo),
    .o_div0 (w_div0)
  );

  assign w_go = start && !flush && is_valid_op(MDUcal);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hi_n  <= '0;
      r_lo_n  <= '0;
      r_upd   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_go) begin
            // Operands are only valid this cycle, so the result is captured
            // now and held in the shadow regs until the latency expires.
            r_state <= BUSY;
            r_cnt   <= is_div(MDUcal) ? DIV_N : MULT_N;
            r_hi_n  <= w_hi;
            r_lo_n  <= w_lo;
            r_upd   <= !w_div0;
          end else if (!flush) begin
            if (MDUwrite == WHI) r_hi <= A;
            else if (MDUwrite == WLO) r_lo <= A;
          end
        end
        BUSY: begin
          if (r_cnt == 4'd1) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            if (r_upd) begin
              r_hi <= r_hi_n;
              r_lo <= r_lo_n;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy  = (r_state == BUSY);
  assign stall = md_D && (busy || (start && !flush));
  assign HI    = r_hi;
  assign LO    = r_lo;

  // The D-stage stall must keep any further md instr out of E while busy.
  a_no_overlap: assert property (@(posedge clk) disable iff (reset)
    busy |-> !(start || (MDUwrite != WR_NONE)));

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  MDUcal;
  logic [3:0]  MDUwrite;
  logic        flush;
  logic [31:0] A;
  logic [31:0] B;
  logic        md_D;
  logic        busy;
  logic        stall;
  logic [31:0] HI;
  logic [31:0] LO;

  mdu_ctrl #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .MDUcal(MDUcal),
    .MDUwrite(MDUwrite), .flush(flush), .A(A), .B(B), .md_D(md_D),
    .busy(busy), .stall(stall), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] m_hi   = 32'h0;
  logic [31:0] m_lo   = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic straight from the op definitions.
  task automatic ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l, output bit d0);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    d0 = 1'b0;
    h  = m_hi;
    l  = m_lo;
    case (op)
      SIGN_MULT: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      ZERO_MULT: begin p = {32'h0, a} * {32'h0, b}; h = p[63:32]; l = p[31:0]; end
      SIGN_DIV: begin
        if (b == 0) d0 = 1'b1;
        else begin q = sa / sb; r = sa % sb; p = 64'(q); l = p[31:0]; p = 64'(r); h = p[31:0]; end
      end
      ZERO_DIV: begin
        if (b == 0) d0 = 1'b1;
        else begin l = a / b; h = a % b; end
      end
      default: ;
    endcase
  endtask

  // Monitor: a busy 1->0 transition is the DUT's "result ready" event.
  initial begin
    bit   prev;
    int   run;
    exp_t e;
    prev = 1'b0;
    run  = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b0;
        run  = 0;
      end else begin
        if (busy) run++;
        else if (prev) begin
          chk("mon_q_nonempty", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("mon_HI", HI, e.hi);
            chk("mon_LO", LO, e.lo);
            chk("mon_busy_len", 32'(run), 32'(e.n));
          end
          run = 0;
        end
        prev = busy;
      end
    end
  end

  task automatic idle_inputs();
    start = 1'b0; MDUcal = MDU_NONE; MDUwrite = WR_NONE; flush = 1'b0; md_D = 1'b0;
  endtask

  // Issue a mult/div at cycle T and follow it through T+N+1.
  // rst_at > 0 asserts reset during busy cycle T+rst_at instead of completing.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic md, input int rst_at);
    logic [31:0] h, l;
    bit          d0;
    int          n;
    exp_t        e;
    ref_op(op, a, b, h, l, d0);
    n = is_div(op) ? 10 : 5;
    @(posedge clk); #1;
    start = 1'b1; MDUcal = op; A = a; B = b; md_D = md;
    if (rst_at == 0) begin
      e.hi = h; e.lo = l; e.n = n;
      sb_q.push_back(e);
      m_hi = h; m_lo = l;
    end
    @(negedge clk);
    chk("stall_T", 32'(stall), 32'(md));
    chk("busy_T", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; MDUcal = MDU_NONE; A = $urandom; B = $urandom;
    for (int k = 1; k <= n; k++) begin
      if (k == rst_at) begin
        reset = 1'b1; #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_HI", HI, 32'h0);
        chk("rst_LO", LO, 32'h0);
        m_hi = 32'h0; m_lo = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        md_D = 1'b0;
        return;
      end
      @(negedge clk);
      chk("busy_in_op", 32'(busy), 32'd1);
      chk("stall_in_op", 32'(stall), 32'(md));
      if (k < n) begin @(posedge clk); #1; end
    end
    @(negedge clk);
    chk("busy_done", 32'(busy), 32'd0);
    chk("stall_done", 32'(stall), 32'd0);
    md_D = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] wr, input logic [31:0] a, input logic fl);
    @(posedge clk); #1;
    MDUwrite = wr; A = a; flush = fl;
    @(posedge clk); #1;
    MDUwrite = WR_NONE; flush = 1'b0;
    if (!fl && wr == WHI) m_hi = a;
    if (!fl && wr == WLO) m_lo = a;
    @(negedge clk);
    chk("wr_HI", HI, m_hi);
    chk("wr_LO", LO, m_lo);
    chk("wr_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    idle_inputs();
    A = '0; B = '0;
    reset = 1'b1;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_HI", HI, 32'h0);
    chk("reset_LO", LO, 32'h0);
    chk("reset_stall", 32'(stall), 32'd0);
    reset = 1'b0;

    // Give HI/LO non-zero contents so the mid-op reset has something to clear.
    do_write(WHI, 32'hDEADBEEF, 1'b0);
    do_write(WLO, 32'hCAFEF00D, 1'b0);
    do_op(SIGN_MULT, 32'd100, 32'd7, 1'b1, 3);
    do_op(ZERO_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0);

    do_op(SIGN_MULT, 32'hFFFFFFFE, 32'd3, 1'b1, 0);
    chk("smul_HI", HI, 32'hFFFFFFFF);
    chk("smul_LO", LO, 32'hFFFFFFFA);

    do_op(SIGN_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 0);
    chk("sdiv_HI", HI, 32'hFFFFFFFF);
    chk("sdiv_LO", LO, 32'hFFFFFFFD);
    do_op(ZERO_DIV, 32'd7, 32'd0, 1'b1, 0);
    chk("div0_HI", HI, 32'hFFFFFFFF);
    chk("div0_LO", LO, 32'hFFFFFFFD);

    do_write(WHI, 32'h12345678, 1'b0);
    chk("mthi_LO_kept", LO, 32'hFFFFFFFD);
    do_write(WLO, 32'h55AA55AA, 1'b1);

    // start with flush: nothing happens, no stall
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; MDUcal = ZERO_MULT; md_D = 1'b1; A = 32'd9; B = 32'd9;
    @(negedge clk);
    chk("flush_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_HI", HI, m_hi);
    chk("flush_LO", LO, m_lo);

    // undefined opcode behaves as none
    @(posedge clk); #1;
    start = 1'b1; MDUcal = 4'd9;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("undef_busy", 32'(busy), 32'd0);

    // randomized mix
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        do_write(($urandom_range(0, 1) == 0) ? WHI : WLO, $urandom, 1'($urandom_range(0, 1)));
      end else begin
        op = 4'($urandom_range(1, 4));
        a  = $urandom;
        b  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
        if (op == SIGN_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
        do_op(op, a, b, 1'($urandom_range(0, 1)), 0);
        chk("rand_HI", HI, m_hi);
        chk("rand_LO", LO, m_lo);
      end
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
